// File: rtl/uart_test_pkg.sv
// Shared types and PRBS-8 helper for the UART echo checker.
// The LFSR polynomial is x^8+x^6+x^5+x^4+1, shifting toward bit 7.
package uart_test_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  // Feedback taps at bit positions 7,5,4,3 (polynomial terms 8,6,5,4)
  localparam logic [7:0] PRBS8_TAPS = 8'hB8;

  function automatic logic [7:0] prbs8_next(input logic [7:0] s);
    return {s[6:0], ^(s & PRBS8_TAPS)};
  endfunction

endpackage

// File: rtl/uart_echo_checker_prbs8.sv
// PRBS-8 byte generator: holds the current byte, reloads on load, steps on advance.
module prbs8
  import uart_test_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] seed,
  input  logic       advance,
  output logic [7:0] value
);

  logic [7:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = seed;
    end else if (advance) begin
      value_d = prbs8_next(value_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= SEED;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/uart_echo_checker.sv
// Drives a PRBS-8 byte stream into the UART transmitter and checks the echoed
// bytes against a second PRBS copy; reports pass, error/receive counts and timeout.
module uart_echo_checker
  import uart_test_pkg::*;
#(
  parameter int         NUM_BYTES       = 256,
  parameter int         MAX_OUTSTANDING = 2,
  parameter int         TIMEOUT_CYCLES  = 250_000,
  parameter logic [7:0] SEED            = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [7:0]  tx_data,
  output logic        tx_trigger,
  input  logic        tx_busy,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [15:0] err_count,
  output logic [15:0] rx_count
);

  localparam int              TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [15:0]     NUM_B = 16'(NUM_BYTES);
  localparam logic [3:0]      MAX_O = 4'(MAX_OUTSTANDING);
  localparam logic [TW-1:0]   TMO   = TW'(TIMEOUT_CYCLES);

  if (SEED == 8'h00) begin : g_bad_seed
    $error("uart_echo_checker: SEED 8'h00 locks the LFSR");
  end

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Reset asserts asynchronously but releases on a clock edge
  logic [1:0] rst_sync_q, rst_sync_d;
  logic       rst_n_i;

  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= rst_sync_d;
  end

  assign rst_n_i = rst_sync_q[1];

  state_t        state_q, state_d;
  logic [15:0]   sent_q, sent_d;
  logic [3:0]    outstanding_q, outstanding_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [15:0]   err_q, err_d;
  logic [15:0]   rx_cnt_q, rx_cnt_d;
  logic          timeout_q, timeout_d;
  logic          pass_q, pass_d;
  logic          tx_trig_q, tx_trig_d;
  logic [7:0]    tx_data_q, tx_data_d;

  logic          active, send, rx_cmp, stray, mismatch, load, expired;
  logic [7:0]    tx_value, exp_value;

  prbs8 #(.SEED(SEED)) u_tx_prbs (
    .clk(clk), .rst_n(rst_n_i), .load(load), .seed(SEED), .advance(send), .value(tx_value)
  );

  prbs8 #(.SEED(SEED)) u_exp_prbs (
    .clk(clk), .rst_n(rst_n_i), .load(load), .seed(SEED), .advance(rx_cmp), .value(exp_value)
  );

  always_comb begin
    active   = (state_q == RUN) || (state_q == DRAIN);
    expired  = (timer_q == TMO);
    // tx_trig_q guard absorbs the one-cycle lag before the transmitter raises busy
    send     = (state_q == RUN) && (sent_q < NUM_B) && !tx_busy &&
               (outstanding_q < MAX_O) && !tx_trig_q && !expired;
    rx_cmp   = active && rx_valid && (outstanding_q != 4'd0);
    stray    = active && rx_valid && (outstanding_q == 4'd0);
    mismatch = rx_cmp && (rx_data != exp_value);
    load     = 1'b0;

    state_d   = state_q;
    timeout_d = timeout_q;
    pass_d    = pass_q;
    tx_trig_d = send;
    tx_data_d = send ? tx_value : tx_data_q;
    sent_d    = send ? sent_q + 16'd1 : sent_q;
    err_d     = (mismatch || stray) ? sat_inc16(err_q) : err_q;
    rx_cnt_d  = rx_cmp ? rx_cnt_q + 16'd1 : rx_cnt_q;

    case ({send, rx_cmp})
      2'b10:   outstanding_d = outstanding_q + 4'd1;
      2'b01:   outstanding_d = outstanding_q - 4'd1;
      default: outstanding_d = outstanding_q;
    endcase

    if (!active || send || rx_valid || (outstanding_q == 4'd0)) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TW'(1);
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          load          = 1'b1;
          state_d       = RUN;
          err_d         = '0;
          rx_cnt_d      = '0;
          sent_d        = '0;
          outstanding_d = '0;
          timer_d       = '0;
          timeout_d     = 1'b0;
          pass_d        = 1'b0;
        end
      end
      RUN: begin
        if (expired) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end else if (sent_q == NUM_B) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (expired) begin
          state_d   = DONE;
          timeout_d = 1'b1;
        end else if (outstanding_d == 4'd0) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Verdict uses next-state counters so the final compare is included
    if ((state_d == DONE) && (state_q != DONE)) begin
      pass_d = (err_d == 16'd0) && !timeout_d && (rx_cnt_d == NUM_B);
    end
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= IDLE;
      sent_q        <= '0;
      outstanding_q <= '0;
      timer_q       <= '0;
      err_q         <= '0;
      rx_cnt_q      <= '0;
      timeout_q     <= 1'b0;
      pass_q        <= 1'b0;
      tx_trig_q     <= 1'b0;
      tx_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      sent_q        <= sent_d;
      outstanding_q <= outstanding_d;
      timer_q       <= timer_d;
      err_q         <= err_d;
      rx_cnt_q      <= rx_cnt_d;
      timeout_q     <= timeout_d;
      pass_q        <= pass_d;
      tx_trig_q     <= tx_trig_d;
      tx_data_q     <= tx_data_d;
    end
  end

  assign tx_data    = tx_data_q;
  assign tx_trigger = tx_trig_q;
  assign busy       = (state_q == RUN) || (state_q == DRAIN);
  assign done       = (state_q == DONE);
  assign pass       = pass_q;
  assign timeout    = timeout_q;
  assign err_count  = err_q;
  assign rx_count   = rx_cnt_q;

endmodule
